irq_priority_ctrl: RTL and testbench

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

---
 rtl/soc_irq_pkg.sv | 19 +
 rtl/irq_prio_enc.sv | 29 ++
 rtl/irq_priority_ctrl.sv | 126 ++++++++++++
 tb/tb_irq_priority_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_irq_pkg.sv
// ---------------------------------------------------------------------------
// soc_irq_pkg
//   Shared definitions for the interrupt priority controller:
//     NUM_SRC     - number of interrupt sources
//     SEL_W       - width of a source index
//     irq_state_t - handshake FSM state encoding
// ---------------------------------------------------------------------------
package soc_irq_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_REL = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
//   Combinational fixed-priority encoder, highest index wins.
//   Ports:
//     i_eligible [NUM_SRC-1:0] - candidate sources
//     o_idx      [SEL_W-1:0]   - index of highest set bit (0 when none)
//     o_valid                  - at least one bit of i_eligible is set
// ---------------------------------------------------------------------------
module irq_prio_enc
  import soc_irq_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_eligible,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_valid
);

  // Ascending scan: a later (higher) set bit overwrites a lower one.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_eligible[i]) begin
        o_idx = SEL_W'(i);
      end
    end
  end

  assign o_valid = |i_eligible;

endmodule

// File: rtl/irq_priority_ctrl.sv
// ---------------------------------------------------------------------------
// irq_priority_ctrl
//   Edge-triggered interrupt collector with per-source mask, sticky overflow
//   flags and a non-preemptive irq/iack handshake to the CPU.
//   Ports:
//     clk, rst   - clock, synchronous active-high reset
//     req        - request lines, rising edge latches pending
//     mask_we    - write mask_d into the mask register
//     mask_d     - mask write data (1 = source enabled)
//     iack       - CPU acknowledge level, held until irq drops
//     ovf_clr    - clears all overflow flags
//     irq        - registered interrupt request to CPU
//     prio_sel   - index of the source currently being served
//     pending    - pending flags
//     ovf        - sticky overflow flags
//     mask_q     - current mask register
// ---------------------------------------------------------------------------
module irq_priority_ctrl
  import soc_irq_pkg::*;
#(
  parameter logic [NUM_SRC-1:0] RESET_MASK = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_d,
  input  logic               iack,
  input  logic               ovf_clr,
  output logic               irq,
  output logic [SEL_W-1:0]   prio_sel,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] ovf,
  output logic [NUM_SRC-1:0] mask_q
);

  logic [NUM_SRC-1:0] r_req_d;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_ovf;
  logic [NUM_SRC-1:0] r_mask;
  logic               r_irq;
  logic [SEL_W-1:0]   r_sel;
  irq_state_t         r_state;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_ovf_set;
  logic [NUM_SRC-1:0] w_eligible;
  logic [SEL_W-1:0]   w_enc_idx;
  logic               w_enc_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_edge[gi] = req[gi] & ~r_req_d[gi];
      // Acknowledge clears only the bit latched in prio_sel.
      assign w_clr[gi]  = (r_state == ASSERT) && iack && (r_sel == SEL_W'(gi));
      // A repeat edge that lands on the acknowledge cycle simply re-arms the
      // bit, so it is not counted as an overflow.
      assign w_ovf_set[gi] = w_edge[gi] & r_pending[gi] & ~w_clr[gi];
    end
  endgenerate

  assign w_eligible = r_pending & r_mask;

  irq_prio_enc u_prio_enc (
    .i_eligible (w_eligible),
    .o_idx      (w_enc_idx),
    .o_valid    (w_enc_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d   <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
      r_mask    <= RESET_MASK;
      r_irq     <= 1'b0;
      r_sel     <= '0;
      r_state   <= IDLE;
    end else begin
      r_req_d   <= req;
      // Set wins over clear.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      // A new overflow event wins over ovf_clr.
      r_ovf     <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
      if (mask_we) begin
        r_mask <= mask_d;
      end

      // Selection happens only in IDLE, so prio_sel is frozen for the whole
      // handshake and mask changes cannot retract an asserted irq.
      case (r_state)
        IDLE: begin
          if (w_enc_valid) begin
            r_sel   <= w_enc_idx;
            r_irq   <= 1'b1;
            r_state <= ASSERT;
          end
        end
        ASSERT: begin
          if (iack) begin
            r_irq   <= 1'b0;
            r_state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!iack) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign irq      = r_irq;
  assign prio_sel = r_sel;
  assign pending  = r_pending;
  assign ovf      = r_ovf;
  assign mask_q   = r_mask;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;

  localparam logic [3:0] RST_MASK = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       mask_we = 1'b0;
  logic [3:0] mask_d = 4'b0000;
  logic       iack = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       irq;
  logic [1:0] prio_sel;
  logic [3:0] pending;
  logic [3:0] ovf;
  logic [3:0] mask_q;

  irq_priority_ctrl #(.RESET_MASK(RST_MASK)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mask_we  (mask_we),
    .mask_d   (mask_d),
    .iack     (iack),
    .ovf_clr  (ovf_clr),
    .irq      (irq),
    .prio_sel (prio_sel),
    .pending  (pending),
    .ovf      (ovf),
    .mask_q   (mask_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irq;
    logic [1:0] sel;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic [3:0] mask;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (0 = idle, 1 = irq raised, 2 = waiting for release)
  int         m_st   = 0;
  logic       m_irq  = 1'b0;
  logic [1:0] m_sel  = 2'b00;
  logic [3:0] m_reqd = 4'b0000;
  logic [3:0] m_pend = 4'b0000;
  logic [3:0] m_ovf  = 4'b0000;
  logic [3:0] m_mask = RST_MASK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [1:0] top_src(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  // Advance the model by one edge with the currently driven inputs.
  task automatic model_step();
    logic [3:0] rise;
    logic [3:0] ack_clr;
    logic [3:0] elig;
    if (rst) begin
      m_st = 0; m_irq = 1'b0; m_sel = 2'b00;
      m_reqd = 4'b0; m_pend = 4'b0; m_ovf = 4'b0; m_mask = RST_MASK;
      return;
    end
    rise    = req & ~m_reqd;
    ack_clr = (m_st == 1 && iack) ? (4'b0001 << m_sel) : 4'b0000;
    elig    = m_pend & m_mask;
    m_ovf   = (ovf_clr ? 4'b0000 : m_ovf) | (rise & m_pend & ~ack_clr);
    m_pend  = (m_pend & ~ack_clr) | rise;
    m_reqd  = req;
    if (mask_we) m_mask = mask_d;
    if (m_st == 0) begin
      if (elig != 4'b0) begin
        m_sel = top_src(elig); m_irq = 1'b1; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (iack) begin
        m_irq = 1'b0; m_st = 2;
      end
    end else begin
      if (!iack) m_st = 0;
    end
  endtask

  // One clock: push expectation for the driven inputs, then pop and compare.
  task automatic tick();
    exp_t e;
    model_step();
    sb_q.push_back({m_irq, m_sel, m_pend, m_ovf, m_mask});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk("irq",      {7'b0, irq},      {7'b0, e.irq});
      chk("prio_sel", {6'b0, prio_sel}, {6'b0, e.sel});
      chk("pending",  {4'b0, pending},  {4'b0, e.pend});
      chk("ovf",      {4'b0, ovf},      {4'b0, e.ovf});
      chk("mask_q",   {4'b0, mask_q},   {4'b0, e.mask});
    end
    $display("cyc t=%0t rst=%b req=%b iack=%b we=%b ovf_clr=%b -> irq=%b sel=%0d pend=%b ovf=%b mask=%b",
             $time, rst, req, iack, mask_we, ovf_clr, irq, prio_sel, pending, ovf, mask_q);
  endtask

  task automatic handshake();
    iack = 1'b1; tick();
    chk("hs_irq_drop", {7'b0, irq}, 8'd0);
    iack = 1'b0; tick();
  endtask

  initial begin
    // Reset
    rst = 1'b1; tick(); tick();
    chk("rst_irq",  {7'b0, irq}, 8'd0);
    chk("rst_pend", {4'b0, pending}, 8'h00);
    chk("rst_mask", {4'b0, mask_q}, {4'b0, RST_MASK});
    rst = 1'b0; tick();

    // Single source 2
    req = 4'b0100; tick();
    chk("s1_pend", {4'b0, pending}, 8'h04);
    chk("s1_irq_early", {7'b0, irq}, 8'd0);
    req = 4'b0000; tick();
    chk("s1_irq", {7'b0, irq}, 8'd1);
    chk("s1_sel", {6'b0, prio_sel}, 8'd2);
    handshake();
    chk("s1_pend_clr", {4'b0, pending}, 8'h00);

    // Sources 0 and 3 together: 3 served first, then 0
    req = 4'b1001; tick();
    req = 4'b0000; tick();
    chk("s2_sel_a", {6'b0, prio_sel}, 8'd3);
    handshake();
    tick();
    chk("s2_irq_b", {7'b0, irq}, 8'd1);
    chk("s2_sel_b", {6'b0, prio_sel}, 8'd0);
    handshake();

    // Overflow, ovf_clr, and edge coinciding with acknowledge
    req = 4'b0010; tick();
    req = 4'b0000; tick();
    req = 4'b0010; tick();
    chk("s3_ovf", {4'b0, ovf}, 8'h02);
    req = 4'b0000; ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    chk("s3_ovf_clr", {4'b0, ovf}, 8'h00);
    req = 4'b0010; iack = 1'b1; tick();
    chk("s3_pend_keep", {4'b0, pending}, 8'h02);
    chk("s3_ovf_none", {4'b0, ovf}, 8'h00);
    req = 4'b0000; iack = 1'b0; tick();
    tick();
    chk("s3_reserve", {6'b0, prio_sel}, 8'd1);
    handshake();

    // Masked source then unmask
    mask_we = 1'b1; mask_d = 4'b1110; tick();
    mask_we = 1'b0;
    req = 4'b0001; tick();
    req = 4'b0000; tick(); tick();
    chk("s4_pend", {4'b0, pending}, 8'h01);
    chk("s4_irq_masked", {7'b0, irq}, 8'd0);
    mask_we = 1'b1; mask_d = 4'b1111; tick();
    mask_we = 1'b0; tick();
    chk("s4_irq", {7'b0, irq}, 8'd1);
    chk("s4_sel", {6'b0, prio_sel}, 8'd0);
    handshake();

    // No preemption
    req = 4'b0010; tick();
    req = 4'b0000; tick();
    req = 4'b1000; tick();
    req = 4'b0000; tick();
    chk("s5_sel_hold", {6'b0, prio_sel}, 8'd1);
    handshake();
    tick();
    chk("s5_sel_next", {6'b0, prio_sel}, 8'd3);
    handshake();

    // iack ignored in idle
    mask_we = 1'b1; mask_d = 4'b0000; tick();
    mask_we = 1'b0; req = 4'b0100; tick();
    req = 4'b0000; iack = 1'b1; tick(); tick();
    chk("s7_idle_iack", {4'b0, pending}, 8'h04);
    iack = 1'b0; mask_we = 1'b1; mask_d = 4'b1111; tick();
    mask_we = 1'b0; tick();
    handshake();

    // Reset in WAIT_REL with pending=1010
    req = 4'b1010; tick();
    req = 4'b0000; tick();
    iack = 1'b1; tick();
    req = 4'b1000; mask_we = 1'b1; mask_d = 4'b0011; tick();
    req = 4'b0010; mask_we = 1'b0; tick();
    chk("s6_pend_pre", {4'b0, pending}, 8'h0A);
    chk("s6_ovf_pre", {4'b0, ovf}, 8'h02);
    req = 4'b0000; rst = 1'b1; tick();
    chk("s6_irq", {7'b0, irq}, 8'd0);
    chk("s6_pend", {4'b0, pending}, 8'h00);
    chk("s6_ovf", {4'b0, ovf}, 8'h00);
    chk("s6_mask", {4'b0, mask_q}, {4'b0, RST_MASK});
    rst = 1'b0; iack = 1'b0; tick(); tick();
    chk("s6_idle", {7'b0, irq}, 8'd0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      req     = 4'($urandom_range(0, 15));
      iack    = ($urandom_range(0, 2) == 0) ? ~iack : iack;
      ovf_clr = ($urandom_range(0, 9) == 0);
      mask_we = ($urandom_range(0, 11) == 0);
      mask_d  = 4'($urandom_range(0, 15));
      rst     = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
